// File: rtl/led_pattern_engine.sv
// Pattern engine for an N-wide LED bus: heartbeat, chase, bounce and fill.
// Mode and period are taken only at frame boundaries so a running pattern never tears.
module led_pattern_engine #(
  parameter int N_LEDS    = 8,
  parameter int PERIOD_W  = 2,
  parameter int STEP_BASE = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_enable,
  input  logic [1:0]          io_mode,
  input  logic [PERIOD_W-1:0] io_period,
  output logic [N_LEDS-1:0]   io_out,
  output logic                io_frameEnd
);

  localparam int STEP_SPAN = (2 * N_LEDS - 2 > 8) ? 2 * N_LEDS - 2 : 8;
  localparam int STEP_W    = $clog2(STEP_SPAN);
  localparam int DIV_MAX   = (2 ** PERIOD_W) * STEP_BASE - 1;
  localparam int DIV_W     = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);

  localparam logic [STEP_W-1:0] LAST_HB    = STEP_W'(7);
  localparam logic [STEP_W-1:0] LAST_LIN   = STEP_W'(N_LEDS - 1);
  localparam logic [STEP_W-1:0] LAST_BN    = STEP_W'(2 * N_LEDS - 3);
  localparam logic [STEP_W-1:0] BOUNCE_TOP = STEP_W'(2 * N_LEDS - 2);
  localparam logic [STEP_W-1:0] N_STEP     = STEP_W'(N_LEDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          mode_reg, mode_next;
  logic [PERIOD_W-1:0] period_reg, period_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic [DIV_W-1:0]    div_reg, div_next;

  logic [DIV_W-1:0]    div_last;
  logic [STEP_W-1:0]   step_last;
  logic [STEP_W-1:0]   bounce_pos;
  logic                running, step_done, frame_last;
  logic                hb_on;
  logic [N_LEDS-1:0]   lit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      mode_reg   <= '0;
      period_reg <= '0;
      step_reg   <= '0;
      div_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      period_reg <= period_next;
      step_reg   <= step_next;
      div_reg    <= div_next;
    end
  end

  always_comb begin
    div_last = DIV_W'((32'(period_reg) + 32'd1) * STEP_BASE - 1);
    case (mode_reg)
      2'd0:    step_last = LAST_HB;
      2'd2:    step_last = LAST_BN;
      default: step_last = LAST_LIN;
    endcase
  end

  assign running     = (state_reg == RUN);
  assign step_done   = (div_reg == div_last);
  assign frame_last  = (step_reg == step_last);
  assign io_frameEnd = running && step_done && frame_last;

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    period_next = period_reg;
    step_next   = step_reg;
    div_next    = div_reg;
    case (state_reg)
      IDLE: begin
        if (io_enable) begin
          state_next  = RUN;
          mode_next   = io_mode;
          period_next = io_period;
          step_next   = '0;
          div_next    = '0;
        end
      end
      default: begin
        if (!io_enable) begin
          // Disable wins over a coincident frame end: no relatch.
          state_next = IDLE;
          step_next  = '0;
          div_next   = '0;
        end else if (step_done) begin
          div_next = '0;
          if (frame_last) begin
            step_next   = '0;
            mode_next   = io_mode;
            period_next = io_period;
          end else begin
            step_next = step_reg + STEP_W'(1);
          end
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
    endcase
  end

  // Output is decoded only from registered state, never from the inputs.
  assign hb_on      = (step_reg == STEP_W'(0)) || (step_reg == STEP_W'(2));
  assign bounce_pos = (step_reg < N_STEP) ? step_reg : BOUNCE_TOP - step_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_led
      localparam logic [STEP_W-1:0] IDX = STEP_W'(gi);
      assign lit[gi] = ((mode_reg == 2'd0) && hb_on)
                    || ((mode_reg == 2'd1) && (step_reg == IDX))
                    || ((mode_reg == 2'd2) && (bounce_pos == IDX))
                    || ((mode_reg == 2'd3) && (step_reg >= IDX));
    end
  endgenerate

  assign io_out = running ? lit : '0;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: directed test-plan sequences then random traffic,
// checked against a cycle-count model of frames and steps.
module tb_led_pattern_engine;

  localparam int N  = 8;
  localparam int PW = 2;
  localparam int SB = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_enable;
  logic [1:0]    io_mode;
  logic [PW-1:0] io_period;
  logic [N-1:0]  io_out;
  logic          io_frameEnd;

  int checks = 0;
  int errors = 0;

  // Model: running flag, latched mode/period, and cycle count t inside the frame.
  int m_run, m_mode, m_period, m_t;

  led_pattern_engine #(.N_LEDS(N), .PERIOD_W(PW), .STEP_BASE(SB)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_enable  (io_enable),
    .io_mode    (io_mode),
    .io_period  (io_period),
    .io_out     (io_out),
    .io_frameEnd(io_frameEnd)
  );

  always #5 clock = ~clock;

  function automatic int flen(int md);
    if (md == 0) return 8;
    if (md == 2) return 2 * N - 2;
    return N;
  endfunction

  function automatic int hold_len();
    return (m_period + 1) * SB;
  endfunction

  function automatic int m_step();
    return m_t / hold_len();
  endfunction

  function automatic logic [N-1:0] exp_out();
    int s, pos, v;
    if (m_run == 0) return '0;
    s = m_step();
    case (m_mode)
      0: v = (s == 0 || s == 2) ? (1 << N) - 1 : 0;
      1: v = 1 << s;
      2: begin
        pos = (s < N) ? s : 2 * N - 2 - s;
        v = 1 << pos;
      end
      default: v = (1 << (s + 1)) - 1;
    endcase
    return N'(v);
  endfunction

  function automatic logic exp_fe();
    if (m_run == 0) return 1'b0;
    return (m_t == flen(m_mode) * hold_len() - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (m_run == 0) begin
      if (io_enable) begin
        m_run = 1; m_mode = io_mode; m_period = io_period; m_t = 0;
      end
    end else if (!io_enable) begin
      m_run = 0; m_t = 0;
    end else begin
      m_t++;
      if (m_t == flen(m_mode) * hold_len()) begin
        m_t = 0; m_mode = io_mode; m_period = io_period;
      end
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("out", 32'(io_out), 32'(exp_out()));
      chk("frameEnd", 32'(io_frameEnd), 32'(exp_fe()));
      $display("t=%0t en=%0b mode=%0d per=%0d out=%h fe=%0b", $time, io_enable, io_mode,
               io_period, io_out, io_frameEnd);
      @(posedge clock);
      model_edge();
      #1;
    end
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #2;
    chk("async_reset_out", 32'(io_out), 32'd0);
    chk("async_reset_fe", 32'(io_frameEnd), 32'd0);
    m_run = 0; m_t = 0; m_mode = 0; m_period = 0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    m_run = 0; m_mode = 0; m_period = 0; m_t = 0;
    reset = 1'b1; io_enable = 1'b1; io_mode = 2'd1; io_period = '0;
    #12;
    chk("reset_out", 32'(io_out), 32'd0);
    chk("reset_fe", 32'(io_frameEnd), 32'd0);
    reset = 1'b0;

    // Chase, one cycle per step, wraps after 0x80.
    cycle(20);

    // Chase with 3-cycle holds; shorten the period while 0x08 shows.
    io_period = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_run == 1 && m_period == 2 && m_step() == 3) begin
        found = 1'b1;
        break;
      end
      cycle(1);
    end
    chk("reach_step3", 32'(found), 32'd1);
    io_period = 2'd0;
    cycle(30);

    // Heartbeat, then switch to fill mid-frame.
    io_mode = 2'd0;
    cycle(12);
    io_mode = 2'd3;
    cycle(20);

    // Bounce, then fill.
    io_mode = 2'd2;
    cycle(40);
    io_mode = 2'd3;
    cycle(20);

    // Drop enable while 0x04 shows; re-enable restarts at step 0.
    io_enable = 1'b0;
    cycle(1);
    io_enable = 1'b1; io_mode = 2'd1; io_period = 2'd0;
    cycle(3);
    chk("showing_04", 32'(io_out), 32'h04);
    io_enable = 1'b0;
    cycle(1);
    chk("blank_after_drop", 32'(io_out), 32'h00);
    io_enable = 1'b1;
    cycle(4);

    // Reset between edges blanks at once.
    mid_reset();
    cycle(10);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) io_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) io_mode = 2'($urandom);
      if ($urandom_range(0, 9) == 0) io_period = PW'($urandom);
      if ($urandom_range(0, 299) == 0) mid_reset();
      cycle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
